frame_check_sequence_inserter: RTL



---
 rtl/frame_check_sequence_inserter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/frame_check_sequence_inserter.sv
`default_nettype none
// ============================================================================
// Module      : frame_check_sequence_inserter
// Description : Pads a transmit frame to a minimum length, then appends the
//               4-byte FCS returned by the external checksum generator.
// Revision    : 1.0
// ============================================================================
module frame_check_sequence_inserter #(
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter logic [7:0]  PAD_BYTE        = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [7:0]  fcs_data,
  output logic        fcs_data_enable,
  output logic        fcs_data_last,
  input  logic [31:0] fcs_checksum,
  input  logic        fcs_checksum_valid
);

  typedef enum logic [1:0] {
    S_DATA     = 2'd0,
    S_PAD      = 2'd1,
    S_WAIT_FCS = 2'd2,
    S_FCS      = 2'd3
  } state_t;

  // One extra bit so the comparison holds even at MIN_FRAME_BYTES = 65535.
  localparam logic [16:0] MIN_COUNT = 17'(MIN_FRAME_BYTES);

  state_t      state_q, state_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;

  logic        out_free;
  logic        load_frame;
  logic        load_pad;
  logic        load_fcs;
  logic        frame_done;
  logic [16:0] count_inc;
  logic [15:0] count_sat;

  assign out_free   = !m_valid_q || m_ready;
  assign count_inc  = {1'b0, byte_count_q} + 17'd1;
  assign count_sat  = (count_inc <= MIN_COUNT) ? count_inc[15:0] : byte_count_q;
  assign frame_done = (count_inc >= MIN_COUNT);

  assign load_frame = (state_q == S_DATA) && s_valid && out_free;
  assign load_pad   = (state_q == S_PAD) && out_free;
  assign load_fcs   = (state_q == S_FCS) && out_free;

  assign s_ready         = (state_q == S_DATA) && out_free;
  assign fcs_data        = (state_q == S_PAD) ? PAD_BYTE : s_data;
  assign fcs_data_enable = load_frame || load_pad;
  assign fcs_data_last   = (load_frame && s_last && frame_done) || (load_pad && frame_done);

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    fcs_idx_d    = fcs_idx_q;
    shift_d      = shift_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    m_valid_d    = m_valid_q && !m_ready;

    case (state_q)
      S_DATA: begin
        if (load_frame) begin
          m_data_d     = s_data;
          m_valid_d    = 1'b1;
          m_last_d     = 1'b0;
          byte_count_d = count_sat;
          if (s_last) begin
            state_d = frame_done ? S_WAIT_FCS : S_PAD;
          end
        end
      end
      S_PAD: begin
        if (load_pad) begin
          m_data_d     = PAD_BYTE;
          m_valid_d    = 1'b1;
          m_last_d     = 1'b0;
          byte_count_d = count_sat;
          if (frame_done) begin
            state_d = S_WAIT_FCS;
          end
        end
      end
      S_WAIT_FCS: begin
        if (fcs_checksum_valid) begin
          shift_d   = fcs_checksum;
          fcs_idx_d = 2'd0;
          state_d   = S_FCS;
        end
      end
      S_FCS: begin
        if (load_fcs) begin
          m_data_d  = shift_q[31:24];
          m_valid_d = 1'b1;
          m_last_d  = (fcs_idx_q == 2'd3);
          shift_d   = {shift_q[23:0], 8'h00};
          fcs_idx_d = fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            state_d      = S_DATA;
            byte_count_d = 16'd0;
          end
        end
      end
      default: begin
        state_d = S_DATA;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_DATA;
      byte_count_q <= 16'd0;
      fcs_idx_q    <= 2'd0;
      shift_q      <= 32'd0;
      m_data_q     <= 8'd0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      fcs_idx_q    <= fcs_idx_d;
      shift_q      <= shift_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
    end
  end

endmodule
`default_nettype wire
